adc_arbiter: RTL and testbench
==============================

ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 Parameter TMO, default 200, 8-bit cycle budget for each converter handshake phase before abort.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the clock rising edge.
REQ-004 soc_a  input  1  start-of-conversion request, requester A.
REQ-005 eoc_a  output 1  end-of-conversion to requester A; 1 = idle or done, 0 = conversion running.
REQ-006 x_a    output 8  sample returned to A; valid when eoc_a rises.
REQ-007 soc_b, eoc_b, x_b  same directions, widths and meanings as REQ-004..006, for requester B.
REQ-008 soc    output 1  start-of-conversion to the shared converter.
REQ-009 eoc    input  1  end-of-conversion from the shared converter.
REQ-010 x      input  8  converter data, valid while eoc=1 after a conversion.
REQ-011 err    output 1  sticky timeout flag.

Function
REQ-012 Converter and requesters shall use one 4-phase handshake: soc 1 -> eoc 0 -> soc 0 -> eoc 1.
REQ-013 All outputs shall be registered; no combinational path from any input to any output.
REQ-014 States: IDLE, START, CONV; state register and grant register gnt (A/B), last-served register last.
REQ-015 IDLE, neither soc_a nor soc_b = 1: hold; soc stays 0.
REQ-016 IDLE, exactly one request = 1: gnt <= that requester, soc <= 1, timer <= TMO, -> START (soc visible 1 cycle after the request is sampled).
REQ-017 IDLE, both requests = 1: gnt <= the requester not equal to last (round robin), same actions as REQ-016.
REQ-018 START, eoc = 0: soc <= 0, eoc_gnt <= 0, timer <= TMO, -> CONV.
REQ-019 CONV, eoc = 1 and soc_gnt = 0: x_gnt <= x, eoc_gnt <= 1, last <= gnt, -> IDLE.
REQ-020 CONV, eoc = 1 and soc_gnt still 1: hold; requester must release soc before data is delivered.
REQ-021 Non-granted requester: eoc and x outputs unchanged for the whole transaction; its request stays pending.
REQ-022 Timer: 8-bit down-counter, decremented each cycle in START/CONV while the awaited condition is false.
REQ-023 Timeout: timer = 1 and awaited condition false -> soc <= 0, eoc_gnt <= 1, x_gnt unchanged, err <= 1, last <= gnt, -> IDLE.
REQ-024 Timeout in START shall leave the requester's soc pending; it shall be re-arbitrated normally.
REQ-025 err shall clear only on reset.
REQ-026 x_a/x_b shall change only at REQ-019 for the granted requester.
REQ-027 Requester dropping soc during START: no effect; the transaction continues and completes per REQ-019.

Reset
REQ-028 reset = 1 at a rising edge: state <= IDLE, soc <= 0, eoc_a <= 1, eoc_b <= 1, x_a <= 0, x_b <= 0, err <= 0, last <= B (A wins the first tie), timer <= 0.
REQ-029 reset shall override every state, including mid-transaction; no pending request is remembered.
REQ-030 After reset deassertion, the first request shall be sampled on the next rising edge.

Verification
REQ-031 Single A: soc_a=1, converter drops eoc after 3 cycles, returns x=8'h5A after 10 more -> soc pulse, eoc_a 1->0->1, x_a=8'h5A, x_b=0, err=0.
REQ-032 Tie: soc_a=soc_b=1 right after reset -> A served first, then B; converter samples 8'h11 and 8'h22 -> x_a=8'h11, x_b=8'h22; eoc_b stays 1 during A's transaction.
REQ-033 Fairness: both held requesting for 6 transactions -> grants alternate A,B,A,B,A,B.
REQ-034 Start timeout: converter holds eoc=1 -> exactly TMO=200 cycles after entering START, soc=0 and err=1; soc_a still high -> new grant in IDLE.
REQ-035 Late release: converter eoc rises while soc_a=1 for 5 more cycles -> x_a/eoc_a update 1 cycle after soc_a falls.
REQ-036 Reset in CONV: reset=1 for 1 cycle -> all outputs at REQ-028 values on that edge; a following soc_b=1 is served normally.

Source files
------------

// File: rtl/adc_arbiter.sv
// rtl/adc_arbiter.sv - round-robin arbiter sharing one 4-phase handshake ADC between two requesters
module adc_arbiter #(
    parameter int TMO = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       soc_a,
    output logic       eoc_a,
    output logic [7:0] x_a,
    input  logic       soc_b,
    output logic       eoc_b,
    output logic [7:0] x_b,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x,
    output logic       err
);
    localparam logic [7:0] TMO_VAL = 8'(TMO);

    typedef enum logic [1:0] {IDLE, START, CONV} state_t;

    state_t     state, state_nx;
    logic       gnt, gnt_nx;     // 0 = A, 1 = B
    logic       last, last_nx;   // 0 = A, 1 = B
    logic [7:0] timer, timer_nx;
    logic       soc_nx, eoc_a_nx, eoc_b_nx, err_nx;
    logic [7:0] x_a_nx, x_b_nx;
    logic       soc_gnt, expired;

    assign soc_gnt = gnt ? soc_b : soc_a;
    assign expired = (timer == 8'd1);

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
        timer_nx = timer;
        soc_nx   = soc;
        eoc_a_nx = eoc_a;
        eoc_b_nx = eoc_b;
        x_a_nx   = x_a;
        x_b_nx   = x_b;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (soc_a || soc_b) begin
                    gnt_nx   = (soc_a && soc_b) ? ~last : soc_b;
                    soc_nx   = 1'b1;
                    timer_nx = TMO_VAL;
                    state_nx = START;
                end
            end
            START: begin
                if (!eoc) begin
                    soc_nx   = 1'b0;
                    timer_nx = TMO_VAL;
                    state_nx = CONV;
                    if (gnt) eoc_b_nx = 1'b0;
                    else     eoc_a_nx = 1'b0;
                end else if (expired) begin
                    // requester soc is untouched, so it is simply re-arbitrated from IDLE
                    soc_nx   = 1'b0;
                    err_nx   = 1'b1;
                    last_nx  = gnt;
                    state_nx = IDLE;
                    if (gnt) eoc_b_nx = 1'b1;
                    else     eoc_a_nx = 1'b1;
                end else begin
                    timer_nx = timer - 8'd1;
                end
            end
            CONV: begin
                if (eoc && !soc_gnt) begin
                    last_nx  = gnt;
                    state_nx = IDLE;
                    if (gnt) begin
                        x_b_nx   = x;
                        eoc_b_nx = 1'b1;
                    end else begin
                        x_a_nx   = x;
                        eoc_a_nx = 1'b1;
                    end
                end else if (expired) begin
                    soc_nx   = 1'b0;
                    err_nx   = 1'b1;
                    last_nx  = gnt;
                    state_nx = IDLE;
                    if (gnt) eoc_b_nx = 1'b1;
                    else     eoc_a_nx = 1'b1;
                end else begin
                    timer_nx = timer - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            timer <= 8'd0;
            soc   <= 1'b0;
            eoc_a <= 1'b1;
            eoc_b <= 1'b1;
            x_a   <= 8'd0;
            x_b   <= 8'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            last  <= last_nx;
            timer <= timer_nx;
            soc   <= soc_nx;
            eoc_a <= eoc_a_nx;
            eoc_b <= eoc_b_nx;
            x_a   <= x_a_nx;
            x_b   <= x_b_nx;
            err   <= err_nx;
        end
    end
endmodule

// File: tb/tb_adc_arbiter.sv
// tb/tb_adc_arbiter.sv - self-checking bench for adc_arbiter with a transaction-level reference model
module tb_adc_arbiter;
    logic       clock = 1'b0;
    logic       reset;
    logic       soc_a, soc_b, eoc;
    logic       eoc_a, eoc_b, soc, err;
    logic [7:0] x, x_a, x_b;

    int         tests = 0;
    int         fails = 0;

    // model state: who was served last (1 = B) and the last sample delivered to each requester
    logic       m_last;
    logic [7:0] m_xa, m_xb;

    always #5 clock = ~clock;

    adc_arbiter #(.TMO(200)) dut (
        .clock(clock),
        .reset(reset),
        .soc_a(soc_a),
        .eoc_a(eoc_a),
        .x_a(x_a),
        .soc_b(soc_b),
        .eoc_b(eoc_b),
        .x_b(x_b),
        .soc(soc),
        .eoc(eoc),
        .x(x),
        .err(err)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        soc_a = 1'b0;
        soc_b = 1'b0;
        eoc   = 1'b1;
        x     = 8'h00;
        tick();
        reset  = 1'b0;
        m_last = 1'b1;
        m_xa   = 8'h00;
        m_xb   = 8'h00;
    endtask

    // Plays converter and granted requester for one complete transaction.
    task automatic serve(input logic [7:0] data, input int d_drop, input int d_rise,
                         input int hold, output logic who_b);
        int   n;
        int   tmax;
        logic exp_b;
        logic stay_ok;
        exp_b = (soc_a && soc_b) ? ~m_last : soc_b;
        n = 0;
        while (soc !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check1("soc_rise", soc, 1'b1);
        repeat (d_drop) tick();
        eoc = 1'b0;
        n = 0;
        while (eoc_a === 1'b1 && eoc_b === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        who_b = (eoc_b === 1'b0);
        check1("grant", who_b, exp_b);
        check1("soc_fall", soc, 1'b0);
        check1("other_eoc", who_b ? eoc_a : eoc_b, 1'b1);
        tmax    = (hold > d_rise) ? hold : d_rise;
        stay_ok = 1'b1;
        for (int t = 0; t <= tmax; t++) begin
            if (t == hold) begin
                if (who_b) soc_b = 1'b0;
                else       soc_a = 1'b0;
            end
            if (t == d_rise) begin
                x   = data;
                eoc = 1'b1;
            end
            if (t < tmax) begin
                tick();
                if ((who_b ? eoc_b : eoc_a) !== 1'b0) stay_ok = 1'b0;
            end
        end
        check1("eoc_held_low", stay_ok, 1'b1);
        tick();
        check1("eoc_done", who_b ? eoc_b : eoc_a, 1'b1);
        check8("x_done", who_b ? x_b : x_a, data);
        check8("x_other", who_b ? x_a : x_b, who_b ? m_xa : m_xb);
        if (who_b) m_xb = data;
        else       m_xa = data;
        m_last = who_b;
    endtask

    initial begin
        logic who;
        logic bad;
        int   r;
        int   cnt;
        reset = 1'b1;
        soc_a = 1'b0;
        soc_b = 1'b0;
        eoc   = 1'b1;
        x     = 8'h00;

        // reset values
        do_reset();
        check1("rst_soc", soc, 1'b0);
        check1("rst_eoc_a", eoc_a, 1'b1);
        check1("rst_eoc_b", eoc_b, 1'b1);
        check8("rst_x_a", x_a, 8'h00);
        check8("rst_x_b", x_b, 8'h00);
        check1("rst_err", err, 1'b0);

        // single A request
        soc_a = 1'b1;
        serve(8'h5A, 3, 10, 0, who);
        check1("single_who", who, 1'b0);
        check8("single_x_a", x_a, 8'h5A);
        check8("single_x_b", x_b, 8'h00);
        check1("single_err", err, 1'b0);

        // tie right after reset: A first, then B
        do_reset();
        soc_a = 1'b1;
        soc_b = 1'b1;
        tick();
        check1("soc_latency", soc, 1'b1);
        serve(8'h11, 2, 2, 1, who);
        check1("tie_first", who, 1'b0);
        serve(8'h22, 1, 3, 0, who);
        check1("tie_second", who, 1'b1);
        check8("tie_x_a", x_a, 8'h11);
        check8("tie_x_b", x_b, 8'h22);

        // fairness with both held requesting
        do_reset();
        soc_a = 1'b1;
        soc_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), who);
            check1("fair_order", who, (i % 2) == 1);
            if (who) soc_b = 1'b1;
            else     soc_a = 1'b1;
        end

        // late release: eoc rises while soc_a still held for 5 more cycles
        do_reset();
        soc_a = 1'b1;
        serve(8'hC3, 2, 1, 6, who);
        check8("late_x_a", x_a, 8'hC3);

        // randomized request patterns
        for (int i = 0; i < 25; i++) begin
            if (!soc_a && !soc_b) begin
                r = $urandom_range(1, 3);
                soc_a = (r & 1) != 0;
                soc_b = (r & 2) != 0;
            end else if (!soc_a) begin
                soc_a = $urandom_range(0, 1) == 1;
            end else if (!soc_b) begin
                soc_b = $urandom_range(0, 1) == 1;
            end
            serve(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5), who);
        end
        check1("rand_err", err, 1'b0);

        // reset while in CONV, then B served normally
        soc_a = 1'b0;
        soc_b = 1'b0;
        tick();
        soc_a = 1'b1;
        tick();
        eoc = 1'b0;
        cnt = 0;
        while (eoc_a === 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check1("conv_entered", eoc_a, 1'b0);
        soc_a = 1'b0;
        reset = 1'b1;
        eoc   = 1'b1;
        tick();
        check1("mid_rst_soc", soc, 1'b0);
        check1("mid_rst_eoc_a", eoc_a, 1'b1);
        check1("mid_rst_eoc_b", eoc_b, 1'b1);
        check8("mid_rst_x_a", x_a, 8'h00);
        check8("mid_rst_x_b", x_b, 8'h00);
        check1("mid_rst_err", err, 1'b0);
        reset  = 1'b0;
        m_last = 1'b1;
        m_xa   = 8'h00;
        m_xb   = 8'h00;
        soc_b  = 1'b1;
        serve(8'h7E, 1, 2, 1, who);
        check1("post_rst_who", who, 1'b1);
        check8("post_rst_x_b", x_b, 8'h7E);

        // start timeout: converter never drops eoc
        do_reset();
        soc_a = 1'b1;
        bad   = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (soc !== 1'b1) bad = 1'b1;
        end
        check1("start_tmo_hold", bad, 1'b0);
        tick();
        check1("start_tmo_soc", soc, 1'b0);
        check1("start_tmo_err", err, 1'b1);
        check1("start_tmo_eoc_a", eoc_a, 1'b1);
        tick();
        check1("regrant_soc", soc, 1'b1);
        repeat (3) tick();
        check1("err_sticky", err, 1'b1);

        // conversion timeout: converter never raises eoc again
        do_reset();
        soc_a = 1'b1;
        tick();
        eoc = 1'b0;
        cnt = 0;
        while (eoc_a === 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        soc_a = 1'b0;
        cnt = 0;
        while (eoc_a === 1'b0 && cnt < 300) begin
            tick();
            cnt++;
        end
        checkn("conv_tmo_cycles", cnt, 200);
        check1("conv_tmo_err", err, 1'b1);
        check8("conv_tmo_x_a", x_a, 8'h00);
        check1("conv_tmo_soc", soc, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
